// File: rtl/div_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Latency 2*WIDTH+1 cycles accept-to-done (1 cycle for B=0 when DIV_DBZ_FAST_EN is defined).
// No backpressure: start is sampled only while busy=0, and results hold until the next completion.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic                 dbz,
    output logic [2*WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]     R
);

    localparam int CNT_W = $clog2(2 * WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [2*WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]     dvs;
    logic [WIDTH-1:0]     prem;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH:0]       trial;
    logic                 fits;
    logic [WIDTH-1:0]     prem_nxt;
    logic [2*WIDTH-1:0]   dvd_nxt;

    // The partial remainder is always < B after a step, so WIDTH bits suffice;
    // the extra trial bit only matters for the compare.
    always_comb begin
        trial    = {prem, dvd[2*WIDTH-1]};
        fits     = (trial >= {1'b0, dvs});
        prem_nxt = fits ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];
        dvd_nxt  = {dvd[2*WIDTH-2:0], fits};
    end

`ifndef DIV_DBZ_FAST_EN
    assign dbz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            dvd   <= '0;
            dvs   <= '0;
            prem  <= '0;
            cnt   <= '0;
`ifdef DIV_DBZ_FAST_EN
            dbz   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef DIV_DBZ_FAST_EN
                        if (B == '0) begin
                            done <= 1'b1;
                            dbz  <= 1'b1;
                            Q    <= '1;
                            R    <= A[WIDTH-1:0];
                        end else begin
                            dvd   <= A;
                            dvs   <= B;
                            prem  <= '0;
                            cnt   <= CNT_W'(2 * WIDTH - 1);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
`else
                        dvd   <= A;
                        dvs   <= B;
                        prem  <= '0;
                        cnt   <= CNT_W'(2 * WIDTH - 1);
                        busy  <= 1'b1;
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    dvd  <= dvd_nxt;
                    prem <= prem_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        Q     <= dvd_nxt;
                        R     <= prem_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef DIV_DBZ_FAST_EN
                        dbz   <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with hand-computed quotients, remainders and cycle counts.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] A;
    logic [31:0] B;
    logic        busy, done, dbz;
    logic [63:0] Q;
    logic [31:0] R;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .Q     (Q),
        .R     (R)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse, then count samples until done (bounded).
    task automatic run_div(input string tag, input logic [63:0] a, input logic [31:0] b,
                           input logic [63:0] eq, input logic [31:0] er, input logic edbz,
                           input int exp_lat, input int exp_busy);
        int lat;
        int nbusy;
        lat = 0;
        nbusy = 0;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        A = ~a;
        B = ~b;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (busy) nbusy++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(nbusy), 64'(exp_busy));
        chk({tag, " busy at done"}, 64'(busy), 64'd0);
        chk({tag, " Q"}, Q, eq);
        chk({tag, " R"}, 64'(R), 64'(er));
        chk({tag, " dbz"}, 64'(dbz), 64'(edbz));
        @(negedge clk);
        chk({tag, " done single pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int k;
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        #23;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset dbz", 64'(dbz), 64'd0);
        chk("reset Q", Q, 64'd0);
        chk("reset R", 64'(R), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("1000/7", 64'd1000, 32'd7, 64'd142, 32'd6, 1'b0, 65, 64);
        run_div("5e9/50000", 64'd5_000_000_000, 32'd50000, 64'd100000, 32'd0, 1'b0, 65, 64);
        run_div("max/max", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'h1_0000_0001, 32'd0, 1'b0, 65, 64);
        run_div("5/9", 64'd5, 32'd9, 64'd0, 32'd5, 1'b0, 65, 64);
`ifdef DIV_DBZ_FAST_EN
        run_div("12345/0", 64'd12345, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd12345, 1'b1, 1, 0);
`else
        run_div("12345/0", 64'd12345, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd12345, 1'b0, 65, 64);
`endif
        run_div("1000/7 after dbz", 64'd1000, 32'd7, 64'd142, 32'd6, 1'b0, 65, 64);

        // Start held high, operands changed mid-run, second op accepted in the done cycle.
        @(negedge clk);
        A = 64'd1000;
        B = 32'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A = 64'd99;
        B = 32'd3;
        n = 0;
        while (n < 200 && !done) begin
            @(negedge clk);
            n++;
        end
        chk("held start first latency", 64'(n + 1), 64'd65);
        chk("held start first Q", Q, 64'd142);
        chk("held start first R", 64'(R), 64'd6);
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (done) break;
        end
        chk("back-to-back spacing", 64'(k), 64'd65);
        chk("second Q", Q, 64'd33);
        chk("second R", 64'(R), 64'd0);

        // Reset in the middle of a run.
        @(negedge clk);
        A = 64'd1000;
        B = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun reset busy", 64'(busy), 64'd0);
        chk("midrun reset done", 64'(done), 64'd0);
        chk("midrun reset Q", Q, 64'd0);
        chk("midrun reset R", 64'(R), 64'd0);
        chk("midrun reset dbz", 64'(dbz), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("no done after reset", 64'(pulses), 64'd0);
        run_div("1000/7 after reset", 64'd1000, 32'd7, 64'd142, 32'd6, 1'b0, 65, 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
